// File: rtl/tmr_fault_monitor.sv
// TMR replica voter with per-replica persistent-fault tracking and health FSM.
// Optional per-replica error counters are enabled by defining TMR_MON_ERR_CNT_EN.
module tmr_fault_monitor #(
    parameter int WIDTH  = 1,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] port_in_0,
    input  logic [WIDTH-1:0] port_in_1,
    input  logic [WIDTH-1:0] port_in_2,
    input  logic             port_valid,
    input  logic             port_clear,
    output logic [WIDTH-1:0] port_out,
    output logic             port_out_valid,
    output logic [2:0]       port_err,
    output logic [2:0]       port_flag,
    output logic [1:0]       port_state,
    output logic [CNT_W-1:0] port_err_cnt_0,
    output logic [CNT_W-1:0] port_err_cnt_1,
    output logic [CNT_W-1:0] port_err_cnt_2
);

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10,
        UNUSED   = 2'b11
    } state_e;

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] THR = RUN_W'(THRESH);

    logic [WIDTH-1:0]            voted;
    logic [2:0]                  mism;
    logic                        triple;
    logic [1:0]                  nflags;
    logic                        fail;

    logic [WIDTH-1:0]            out_q, out_d;
    logic                        out_valid_q, out_valid_d;
    logic [2:0]                  err_q, err_d;
    logic [2:0]                  flag_q, flag_d;
    logic [2:0][RUN_W-1:0]       run_q, run_d;
    state_e                      state_q, state_d;

    always_comb begin
        voted = (port_in_0 & port_in_1) | (port_in_0 & port_in_2)
              | (port_in_1 & port_in_2);
        mism[0] = port_in_0 != voted;
        mism[1] = port_in_1 != voted;
        mism[2] = port_in_2 != voted;
        triple  = (port_in_0 != port_in_1) && (port_in_1 != port_in_2)
               && (port_in_0 != port_in_2);

        out_d       = out_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        run_d       = run_q;
        flag_d      = flag_q;
        state_d     = state_q;

        if (port_valid) begin
            out_d       = voted;
            out_valid_d = 1'b1;
            err_d       = mism;
            for (int k = 0; k < 3; k++) begin
                if (!mism[k])
                    run_d[k] = '0;
                else if (run_q[k] >= THR)
                    run_d[k] = THR;
                else
                    run_d[k] = run_q[k] + 1'b1;
            end
        end

        // Flag and state follow the sample that completes the run.
        for (int k = 0; k < 3; k++)
            if (run_d[k] == THR) flag_d[k] = 1'b1;

        nflags = {1'b0, flag_d[0]} + {1'b0, flag_d[1]} + {1'b0, flag_d[2]};
        fail   = (nflags >= 2'd2) || (port_valid && triple);

        case (state_q)
            NORMAL: begin
                if (fail)
                    state_d = FAILED;
                else if (nflags == 2'd1)
                    state_d = DEGRADED;
            end
            DEGRADED: if (fail) state_d = FAILED;
            FAILED:   state_d = FAILED;
            default:  state_d = NORMAL;
        endcase

        if (port_clear) begin
            run_d   = '0;
            flag_d  = '0;
            state_d = NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
            flag_q      <= '0;
            run_q       <= '0;
            state_q     <= NORMAL;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            flag_q      <= flag_d;
            run_q       <= run_d;
            state_q     <= state_d;
        end
    end

    assign port_out       = out_q;
    assign port_out_valid = out_valid_q;
    assign port_err       = err_q;
    assign port_flag      = flag_q;
    assign port_state     = state_q;

`ifdef TMR_MON_ERR_CNT_EN
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (port_valid) begin
            for (int k = 0; k < 3; k++)
                if (mism[k] && (cnt_q[k] != {CNT_W{1'b1}}))
                    cnt_d[k] = cnt_q[k] + 1'b1;
        end
        if (port_clear) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign port_err_cnt_0 = cnt_q[0];
    assign port_err_cnt_1 = cnt_q[1];
    assign port_err_cnt_2 = cnt_q[2];
`else
    assign port_err_cnt_0 = '0;
    assign port_err_cnt_1 = '0;
    assign port_err_cnt_2 = '0;
`endif

endmodule
